// File: rtl/output_arbiter_if.sv
// Output-port bundle: per-input requests and flits in, granted flit stream out.
interface output_arbiter_if #(
  parameter int PKT_CNT_W = 16
);
  logic [4:0]           req;
  logic [4:0]           in_val;
  logic [159:0]         data_in;
  logic                 out_full;
  logic [4:0]           gnt;
  logic [4:0]           rd;
  logic [31:0]          out_data;
  logic                 out_val;
  logic                 busy;
  logic [PKT_CNT_W-1:0] pkt_cnt;

  modport master (
    output req, in_val, data_in, out_full,
    input  gnt, rd, out_data, out_val, busy, pkt_cnt
  );

  modport slave (
    input  req, in_val, data_in, out_full,
    output gnt, rd, out_data, out_val, busy, pkt_cnt
  );
endinterface

// File: rtl/output_arbiter.sv
// Wormhole round-robin arbiter for one router output port; grant one cycle after request,
// flit registered one cycle after pop; out_full or empty owner FIFO stalls with no pop.
module output_arbiter #(
  parameter int PKT_CNT_W = 16
) (
  input logic             router_clk,
  input logic             reset,
  output_arbiter_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state, state_nxt;
  logic [2:0]           owner, owner_nxt;
  logic [2:0]           ptr, ptr_nxt;
  logic [2:0]           win;
  logic [3:0]           sum;
  logic                 found;
  logic [4:0]           gnt_q, gnt_nxt;
  logic [4:0]           rd_c;
  logic [31:0]          data_q, data_nxt;
  logic [31:0]          flit;
  logic                 val_q, val_nxt;
  logic                 xfer;
  logic [PKT_CNT_W-1:0] cnt_q, cnt_nxt;

  // First requester at or after ptr, wrapping modulo 5.
  always_comb begin
    win   = '0;
    found = 1'b0;
    sum   = '0;
    for (int k = 0; k < 5; k++) begin
      sum = {1'b0, ptr} + 4'(k);
      if (sum >= 4'd5) sum = sum - 4'd5;
      if (!found && bus.req[sum[2:0]]) begin
        found = 1'b1;
        win   = sum[2:0];
      end
    end
  end

  always_comb begin
    flit = bus.data_in[31:0];
    for (int i = 0; i < 5; i++) begin
      if (owner == 3'(i)) flit = bus.data_in[32*i +: 32];
    end
  end

  // gnt_q is the owner's one-hot while BUSY, so it doubles as the pop mask.
  assign xfer = (state == BUSY) && |(bus.in_val & gnt_q) && !bus.out_full;
  assign rd_c = xfer ? gnt_q : 5'b0;

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    gnt_nxt   = gnt_q;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt_q;
    data_nxt  = data_q;
    val_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          owner_nxt = win;
          gnt_nxt   = 5'b00001 << win;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (xfer) begin
          data_nxt = flit;
          val_nxt  = 1'b1;
          // Types 10 and 11 both have bit 30 set and close the packet.
          if (flit[30]) begin
            state_nxt = IDLE;
            gnt_nxt   = 5'b0;
            ptr_nxt   = (owner == 3'd4) ? 3'd0 : owner + 3'd1;
            cnt_nxt   = cnt_q + PKT_CNT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge router_clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      owner  <= '0;
      gnt_q  <= '0;
      ptr    <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      val_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      gnt_q  <= gnt_nxt;
      ptr    <= ptr_nxt;
      cnt_q  <= cnt_nxt;
      data_q <= data_nxt;
      val_q  <= val_nxt;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.rd       = rd_c;
  assign bus.out_data = data_q;
  assign bus.out_val  = val_q;
  assign bus.busy     = (state == BUSY);
  assign bus.pkt_cnt  = cnt_q;
endmodule

// File: doc/output_arbiter.md
OUTPUT_ARBITER -- requirements
Module: output_arbiter

Interface
REQ-001 Parameter: PKT_CNT_W, default 16, width of the completed-packet counter.
REQ-002 router_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low; low clears all state immediately.
REQ-004 req  input  5  per-input-channel request for this output port; bit0 east, bit1 west, bit2 north, bit3 south, bit4 core.
REQ-005 in_val  input  5  per-input-channel flit available at channel head (FIFO not empty).
REQ-006 data_in  input  160  flattened flits; input i occupies bits [32*i+31 : 32*i].
REQ-007 out_full  input  1  downstream FIFO full; high blocks transfer.
REQ-008 gnt  output  5  registered one-hot grant to the owning input channel.
REQ-009 rd  output  5  combinational pop pulse to the owning input channel FIFO.
REQ-010 out_data  output  32  registered flit to the output link.
REQ-011 out_val  output  1  registered; out_data valid this cycle.
REQ-012 busy  output  1  high while a packet owns the port.
REQ-013 pkt_cnt  output  PKT_CNT_W  completed packets, wraps modulo 2^PKT_CNT_W.

Function
REQ-014 Flit type is bits [30:29]: 01 header, 00 body, 10 tailer, 11 single-flit packet; 10 and 11 end a packet.
REQ-015 States: IDLE and BUSY; busy = (state == BUSY).
REQ-016 IDLE, req == 0: remain IDLE, gnt = 0.
REQ-017 IDLE, any req bit set: at next edge, grant winner, go BUSY; grant latency one cycle from request sampled.
REQ-018 Winner is first set req bit searching ptr, ptr+1, ... modulo 5; ptr is a 3-bit round-robin pointer.
REQ-019 BUSY: gnt holds the owner regardless of req changes (wormhole); no re-arbitration until packet end.
REQ-020 rd[owner] = busy & in_val[owner] & !out_full; all other rd bits 0; rd never asserted in IDLE.
REQ-021 At each edge: if rd[owner], out_data loads data_in slice of owner and out_val = 1; else out_val = 0 and out_data holds.
REQ-022 Transfer of an end flit (type 10/11): at that edge gnt = 0, state IDLE, ptr = (owner+1) mod 5, pkt_cnt += 1.
REQ-023 Minimum one IDLE cycle between packets; arbitration for the next packet occurs in that IDLE cycle.
REQ-024 out_full high or in_val[owner] low: stall, no pop, no state change, out_val = 0.
REQ-025 Owner's req falling mid-packet does not release grant; only an end flit releases.
REQ-026 ptr never holds values 5-7; pkt_cnt wraps from all-ones to 0 without flag.

Reset
REQ-027 reset low: state IDLE, gnt = 0, out_val = 0, out_data = 0, ptr = 0, pkt_cnt = 0, immediately and independent of router_clk.
REQ-028 rd is 0 while reset is low.
REQ-029 Reset mid-packet aborts the packet; no pkt_cnt increment; after release arbitration restarts from ptr = 0.
REQ-030 Reset release is synchronised externally; block requires no extra cycles after release.

Verification
REQ-031 Single packet: req = 00001, in_val = 00001, flits 0x2000_0001 / 0x0000_0002 / 0x4000_0003, out_full = 0 -> gnt = 00001 next cycle; three consecutive out_val pulses with those words; pkt_cnt = 1; gnt = 0 after tailer.
REQ-032 Round-robin: req = 11111 held, each input sends a 2-flit packet -> grant order east, west, north, south, core, east; ptr = 1 after sixth grant completes.
REQ-033 Backpressure: out_full = 1 for 4 cycles mid-packet -> rd = 0, out_val = 0, gnt held; transfer resumes with the next flit, none lost or duplicated.
REQ-034 Hold: owner north drops req after header while south requests -> north keeps gnt = 00100 until its tailer; south granted next.
REQ-035 Reset mid-packet: reset low asynchronously during body flit -> gnt = 0, out_val = 0, pkt_cnt = 0 before next edge; after release req = 01000 -> gnt = 01000.
REQ-036 Single-flit packet and counter wrap: PKT_CNT_W = 2, five packets of type 11 from core -> each 1 out_val cycle; pkt_cnt sequence 1,2,3,0,1.
